// File: rtl/seq_mul_shift_add.sv
`default_nettype none
// ============================================================================
// seq_mul_shift_add: radix-2 shift-add multiplier, signed/unsigned, early exit
// Revision: 1.0
// ============================================================================
module seq_mul_shift_add #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 a_neg;
  logic                 b_neg;
  logic                 neg;

  generate
    if (SIGNED_EN) begin : g_sign
      assign a_neg = signed_mode & a[WIDTH-1];
      assign b_neg = signed_mode & b[WIDTH-1];
    end else begin : g_unsigned
      logic unused_signed_mode;
      assign unused_signed_mode = signed_mode;
      assign a_neg = 1'b0;
      assign b_neg = 1'b0;
    end
  endgenerate

  // Magnitude of the most negative value still fits W bits when read unsigned.
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (mplier == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            neg    <= a_neg ^ b_neg;
          end
        end
        CALC: begin
          // Stop as soon as no multiplier bits remain; acc is already final.
          if (mplier != '0) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        FIX: begin
          product <= neg ? (~acc + 1'b1) : acc;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_shift_add.sv
`default_nettype none
// ============================================================================
// tb_seq_mul_shift_add: scoreboard bench with random and directed operations
// Revision: 1.0
// ============================================================================
module tb_seq_mul_shift_add;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  logic           start2 = 1'b0;
  logic           signed_mode2 = 1'b0;
  logic [W-1:0]   a2 = '0;
  logic [W-1:0]   b2 = '0;
  logic           busy2;
  logic           done2;
  logic [2*W-1:0] product2;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic rst_edge = 1'b1;
  exp_t exp_q[$];
  logic [2*W-1:0] last_prod = '0;

  seq_mul_shift_add #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  seq_mul_shift_add #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(signed_mode2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= ~rst_n;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: true integer product and cycle count derived from |b|.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
    longint p;
    logic [63:0] pv;
    if (sm) p = longint'($signed(x)) * longint'($signed(y));
    else    p = longint'(x) * longint'(y);
    pv = p;
    return pv[2*W-1:0];
  endfunction

  function automatic int ref_calc_cycles(input logic [W-1:0] y, input logic sm);
    int m;
    int c;
    m = (sm && y[W-1]) ? (65536 - int'(y)) : int'(y);
    c = 1;
    while (m != 0) begin
      m = m >> 1;
      c++;
    end
    return c;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic sm,
                       input bit hold);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("issue_wait_idle", 64'(busy), 64'd0);
    a           = ta;
    b           = tbv;
    signed_mode = sm;
    start       = 1'b1;
    e.prod = ref_prod(ta, tbv, sm);
    e.cyc  = cyc + ref_calc_cycles(tbv, sm) + 2;
    exp_q.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Monitor: compares every completion against the scoreboard and checks hold/reset.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        last_prod = '0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("product", 64'(product), 64'(e.prod));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("busy_at_done", 64'(busy), 64'd0);
        end
        last_prod = product;
      end else begin
        check("product_hold", 64'(product), 64'(last_prod));
      end
    end
  end

  initial begin
    int guard;
    repeat (2) @(negedge clk);
    check("u_reset_product", 64'(product2), 64'd0);
    rst_n = 1'b1;

    // Directed cases.
    issue(16'd3, 16'd5, 1'b0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    issue(16'h1234, 16'h0000, 1'b0, 1'b0);
    issue(16'hFFFD, 16'd5, 1'b1, 1'b0);
    issue(16'h8000, 16'h8000, 1'b1, 1'b0);
    issue(16'h0000, 16'hFFFF, 1'b1, 1'b0);

    // Start re-asserted with other operands while busy must be ignored.
    issue(16'd3, 16'd5, 1'b0, 1'b0);
    start = 1'b1; a = 16'h7777; b = 16'h00FF;
    @(negedge clk);
    a = 16'h1111; b = 16'h0003;
    @(negedge clk);
    start = 1'b0;

    // Start held through the done cycle: second operation back-to-back.
    issue(16'h0123, 16'h0456, 1'b0, 1'b1);
    issue(16'hFFF0, 16'h0011, 1'b1, 1'b0);

    // Reset during CALC aborts with no done pulse.
    issue(16'd7, 16'h00FF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    void'(exp_q.pop_back());
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(16'd2, 16'd3, 1'b0, 1'b0);

    // Randomised operations.
    for (int i = 0; i < 60; i++) begin
      issue(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), 1'b0);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    // Sign handling removed: signed_mode must be ignored.
    @(negedge clk);
    start2 = 1'b1; signed_mode2 = 1'b1; a2 = 16'hFFFF; b2 = 16'h0002;
    @(negedge clk);
    start2 = 1'b0;
    guard = 0;
    while (!done2 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("u_done_seen", 64'(done2), 64'd1);
    check("u_product", 64'(product2), 64'h0001FFFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
